// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: pipeline entry layout,
// select encoding and select-width derivation.
package hazard_pkg;

    // Entry fields are sized for the widest supported core; narrower AW/latency
    // values are zero-extended into them.
    localparam int ENT_AW = 8;
    localparam int ENT_LW = 4;

    localparam int SEL_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [ENT_AW-1:0] rd;
        logic              we;
        logic [ENT_LW-1:0] lat;
    } entry_t;

    function automatic int sel_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority search for one source operand across all tracked
// stages; yields a hazard flag and the bypass select for the X stage.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int AW       = 5,
    parameter int WD_STALL = 1,
    parameter int SEL_W    = sel_width(DEPTH)
) (
    input  logic [AW-1:0]    rs,
    input  logic             used,
    input  entry_t           stage [DEPTH],
    output logic             hazard,
    output logic [SEL_W-1:0] sel
);

    // Walk oldest to youngest so the youngest match is the last to assign.
    always_comb begin
        hazard = 1'b0;
        sel    = SEL_W'(SEL_RF);
        for (int s = DEPTH-1; s >= 0; s--) begin
            if (used && stage[s].valid && stage[s].we &&
                stage[s].rd != '0 && stage[s].rd == ENT_AW'(rs)) begin
                if (s == DEPTH-1) begin
                    hazard = (WD_STALL != 0);
                    sel    = SEL_W'(SEL_RF);
                end else if (s + 1 < int'(stage[s].lat)) begin
                    hazard = 1'b1;
                    sel    = SEL_W'(SEL_RF);
                end else begin
                    hazard = 1'b0;
                    sel    = SEL_W'(s + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control: tracks in-flight destinations,
// stalls decode on unresolvable hazards and registers X-stage bypass selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int WD_STALL = 1,
    parameter int SEL_W    = sel_width(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     d_valid_i,
    input  logic [NUM_SRC*AW-1:0]    d_rs_i,
    input  logic [NUM_SRC-1:0]       d_rs_used_i,
    input  logic [AW-1:0]            d_rd_i,
    input  logic                     d_we_i,
    input  logic [SEL_W-1:0]         d_lat_i,
    input  logic                     flush_i,
    input  logic                     hold_i,
    output logic                     stall_o,
    output logic [NUM_SRC*SEL_W-1:0] x_bypass_sel_o,
    output logic [AW-1:0]            wb_rd_o,
    output logic                     wb_we_o,
    output logic [31:0]              stall_cycles_o
);

    entry_t                     stage_q [DEPTH];
    entry_t                     dec_ent;
    logic [NUM_SRC-1:0]         haz;
    logic [NUM_SRC*SEL_W-1:0]   sel_c;
    logic [NUM_SRC*SEL_W-1:0]   sel_q;
    logic [31:0]                cnt_q;
    logic                       issue;
    logic                       cnt_inc;

    // Latency 0 behaves as 1; anything past the last stage is clamped to it.
    always_comb begin
        dec_ent       = '0;
        dec_ent.valid = 1'b1;
        dec_ent.rd    = ENT_AW'(d_rd_i);
        dec_ent.we    = d_we_i;
        if (d_lat_i == '0)
            dec_ent.lat = ENT_LW'(1);
        else if (int'(d_lat_i) >= DEPTH)
            dec_ent.lat = ENT_LW'(DEPTH - 1);
        else
            dec_ent.lat = ENT_LW'(d_lat_i);
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_match #(
            .DEPTH   (DEPTH),
            .AW      (AW),
            .WD_STALL(WD_STALL),
            .SEL_W   (SEL_W)
        ) u_match (
            .rs    (d_rs_i[k*AW +: AW]),
            .used  (d_rs_used_i[k]),
            .stage (stage_q),
            .hazard(haz[k]),
            .sel   (sel_c[k*SEL_W +: SEL_W])
        );
    end

    assign stall_o = hold_i | (d_valid_i & (|haz) & ~flush_i);
    assign issue   = d_valid_i & ~stall_o & ~flush_i;
    assign cnt_inc = d_valid_i & stall_o & ~flush_i & ~hold_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            if (!hold_i) begin
                for (int i = DEPTH-1; i > 0; i--) stage_q[i] <= stage_q[i-1];
                stage_q[0] <= issue ? dec_ent : '0;
                sel_q      <= issue ? sel_c : '0;
            end else if (flush_i) begin
                // A taken branch still squashes X while the rest stays frozen.
                stage_q[0] <= '0;
                sel_q      <= '0;
            end
            if (cnt_inc && cnt_q != 32'hFFFF_FFFF)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    assign x_bypass_sel_o = sel_q;
    assign wb_rd_o        = stage_q[DEPTH-1].rd[AW-1:0];
    assign wb_we_o        = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].we;
    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: a driver queues hand-computed expectations per
// cycle; a negedge monitor pops and compares against two DUTs (WD_STALL=1/0).
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid_i;
    logic [9:0]  d_rs_i;
    logic [1:0]  d_rs_used_i;
    logic [4:0]  d_rd_i;
    logic        d_we_i;
    logic [1:0]  d_lat_i;
    logic        flush_i;
    logic        hold_i;

    logic        stall_a, stall_b;
    logic [3:0]  sel_a, sel_b;
    logic [4:0]  wb_rd_a, wb_rd_b;
    logic        wb_we_a, wb_we_b;
    logic [31:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(.DEPTH(3), .NUM_SRC(2), .AW(5), .WD_STALL(1)) dut (
        .clock(clock), .reset(reset), .d_valid_i(d_valid_i), .d_rs_i(d_rs_i),
        .d_rs_used_i(d_rs_used_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i),
        .d_lat_i(d_lat_i), .flush_i(flush_i), .hold_i(hold_i),
        .stall_o(stall_a), .x_bypass_sel_o(sel_a), .wb_rd_o(wb_rd_a),
        .wb_we_o(wb_we_a), .stall_cycles_o(cnt_a)
    );

    hazard_scoreboard #(.DEPTH(3), .NUM_SRC(2), .AW(5), .WD_STALL(0)) dut_b (
        .clock(clock), .reset(reset), .d_valid_i(d_valid_i), .d_rs_i(d_rs_i),
        .d_rs_used_i(d_rs_used_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i),
        .d_lat_i(d_lat_i), .flush_i(flush_i), .hold_i(hold_i),
        .stall_o(stall_b), .x_bypass_sel_o(sel_b), .wb_rd_o(wb_rd_b),
        .wb_we_o(wb_we_b), .stall_cycles_o(cnt_b)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic [3:0]  sel;
        logic [31:0] cnt;
        logic        stall_b;
        logic [3:0]  sel_b;
        logic        chk_wb;
        logic [5:0]  wb;
    } exp_t;

    exp_t q[$];
    logic       nxt_chk_wb = 1'b0;
    logic [5:0] nxt_wb     = '0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "stall",   32'(stall_a), 32'(e.stall));
            cmp(e.name, "sel",     32'(sel_a),   32'(e.sel));
            cmp(e.name, "cnt",     cnt_a,        e.cnt);
            cmp(e.name, "stall_b", 32'(stall_b), 32'(e.stall_b));
            cmp(e.name, "sel_b",   32'(sel_b),   32'(e.sel_b));
            if (e.chk_wb) begin
                cmp(e.name, "wb",   32'({wb_we_a, wb_rd_a}), 32'(e.wb));
                cmp(e.name, "wb_b", 32'({wb_we_b, wb_rd_b}), 32'(e.wb));
            end
        end
    end

    task automatic set_wb(input logic we, input logic [4:0] rd);
        nxt_chk_wb = 1'b1;
        nxt_wb     = {we, rd};
    endtask

    // Drive one decode cycle and queue what the monitor should see in it.
    task automatic step(input string name, input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [1:0] used,
                        input logic [4:0] rd, input logic we, input logic [1:0] lat,
                        input logic fl, input logic hd,
                        input logic es, input logic [3:0] esel, input int ecnt,
                        input logic esb, input logic [3:0] eselb);
        exp_t e;
        d_valid_i   = v;
        d_rs_i      = {rs2, rs1};
        d_rs_used_i = used;
        d_rd_i      = rd;
        d_we_i      = we;
        d_lat_i     = lat;
        flush_i     = fl;
        hold_i      = hd;
        e.name    = name;
        e.stall   = es;
        e.sel     = esel;
        e.cnt     = 32'(ecnt);
        e.stall_b = esb;
        e.sel_b   = eselb;
        e.chk_wb  = nxt_chk_wb;
        e.wb      = nxt_wb;
        nxt_chk_wb = 1'b0;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string name, input logic [3:0] esel, input int ecnt, input logic [3:0] eselb);
        step(name, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, esel, ecnt, 0, eselb);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        d_valid_i   = 1'b0;
        d_rs_i      = '0;
        d_rs_used_i = '0;
        d_rd_i      = '0;
        d_we_i      = 1'b0;
        d_lat_i     = '0;
        flush_i     = 1'b0;
        hold_i      = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        do_reset();

        // Reset state, and stall follows hold with an empty pipeline.
        set_wb(0, 0);
        idle("reset", 4'h0, 0, 4'h0);
        step("reset_hold", 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 4'h0, 0, 1, 4'h0);

        // ALU chain: forward from stage 0.
        do_reset();
        step("alu_prod", 1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("alu_cons", 1, 5, 0, 2'b01, 10, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        idle("alu_sel", 4'b0001, 0, 4'b0001);

        // Load-use: one stall, then forward from stage 1 on source 1.
        do_reset();
        step("ld_prod",  1, 0, 0, 2'b00, 6, 1, 2, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("ld_stall", 1, 0, 6, 2'b10, 11, 1, 1, 0, 0, 1, 4'h0, 0, 1, 4'h0);
        step("ld_issue", 1, 0, 6, 2'b10, 11, 1, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);
        idle("ld_sel", 4'b1000, 1, 4'b1000);

        // WD: producer reaches the last stage; only the WD_STALL=1 copy stalls.
        do_reset();
        step("wd_prod", 1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        idle("wd_b1", 4'h0, 0, 4'h0);
        idle("wd_b2", 4'h0, 0, 4'h0);
        set_wb(1, 9);
        step("wd_stall", 1, 9, 0, 2'b01, 12, 1, 1, 0, 0, 1, 4'h0, 0, 0, 4'h0);
        step("wd_issue", 1, 9, 0, 2'b01, 12, 1, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);
        idle("wd_sel", 4'h0, 1, 4'h0);

        // Non-matches: rd=x0, we=0, and an unused source against a load.
        do_reset();
        step("nm_rd0",    1, 0, 0,  2'b00, 0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("nm_x0",     1, 0, 0,  2'b01, 8, 0, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("nm_we0",    1, 8, 0,  2'b01, 13, 1, 2, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("nm_unused", 1, 0, 13, 2'b01, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        idle("nm_sel", 4'h0, 0, 4'h0);

        // Youngest producer wins.
        do_reset();
        step("yg_a",    1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("yg_b",    1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("yg_cons", 1, 7, 0, 2'b01, 14, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        idle("yg_sel", 4'b0001, 0, 4'b0001);

        // Flush overrides a load-use hazard; bubble follows the producer out.
        do_reset();
        step("fl_prod", 1, 0, 0, 2'b00, 6, 1, 2, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("fl_cons", 1, 6, 0, 2'b01, 15, 1, 1, 1, 0, 0, 4'h0, 0, 0, 4'h0);
        idle("fl_idle", 4'h0, 0, 4'h0);
        set_wb(1, 6);
        idle("fl_wb_prod", 4'h0, 0, 4'h0);
        set_wb(0, 0);
        idle("fl_wb_bubble", 4'h0, 0, 4'h0);

        // Hold: selects and entries frozen, no counting, then hazard resolves.
        do_reset();
        step("hd_prod",  1, 5, 0, 2'b00, 5, 1, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("hd_cons",  1, 5, 0, 2'b01, 6, 1, 2, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("hd_1",     1, 0, 6, 2'b10, 16, 1, 1, 0, 1, 1, 4'b0001, 0, 1, 4'b0001);
        step("hd_2",     1, 0, 6, 2'b10, 16, 1, 1, 0, 1, 1, 4'b0001, 0, 1, 4'b0001);
        step("hd_3",     1, 0, 6, 2'b10, 16, 1, 1, 0, 1, 1, 4'b0001, 0, 1, 4'b0001);
        step("hd_rel",   1, 0, 6, 2'b10, 16, 1, 1, 0, 0, 1, 4'b0001, 0, 1, 4'b0001);
        step("hd_issue", 1, 0, 6, 2'b10, 16, 1, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);
        idle("hd_sel", 4'b1000, 1, 4'b1000);

        // Latency beyond the last stage clamps to DEPTH-1.
        do_reset();
        step("cl_prod",  1, 0, 0, 2'b00, 4, 1, 3, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        step("cl_stall", 1, 4, 0, 2'b01, 0, 0, 1, 0, 0, 1, 4'h0, 0, 1, 4'h0);
        step("cl_issue", 1, 4, 0, 2'b01, 0, 0, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);
        idle("cl_sel", 4'b0010, 1, 4'b0010);

        @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
